mem_access: RTL

Memory-stage access unit of the five-stage pipeline, directly downstream of the decode control unit. It consumes the `memread`, `memwrite`, `byteword`, `memtoreg` and `regwrite` bits carried through EX/MEM, and performs byte/word loads and stores over a req/ack data-memory port. It stalls the pipeline while an access is outstanding and owns the MEM/WB pipeline register.

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_access.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared types and encodings for the memory-stage access unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam logic BW_BYTE = 1'b0;
    localparam logic BW_WORD = 1'b1;

    typedef enum logic [0:0] {
        MA_IDLE = 1'b0,
        MA_BUSY = 1'b1
    } ma_state_e;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dst;
    } memwb_t;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module   : mem_lane_align
// Brief    : Byte-lane steering for stores/loads plus misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic        access_i,
    input  logic        memwrite_i,
    input  logic        byteword_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    always_comb begin
        be_o = 4'hF;
        if (memwrite_i && (byteword_i == BW_BYTE)) begin
            be_o = 4'b0001 << lane_i;
        end

        // Byte stores replicate into every lane so the memory only needs the enables.
        wdata_o = (byteword_i == BW_BYTE) ? {4{store_data_i[7:0]}} : store_data_i;

        rdata_o = rdata_i;
        if (byteword_i == BW_BYTE) begin
            case (lane_i)
                2'd0:    rdata_o = {24'h0, rdata_i[7:0]};
                2'd1:    rdata_o = {24'h0, rdata_i[15:8]};
                2'd2:    rdata_o = {24'h0, rdata_i[23:16]};
                default: rdata_o = {24'h0, rdata_i[31:24]};
            endcase
        end

        misaligned_o = access_i && (byteword_i == BW_WORD) && (lane_i != 2'b00);
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module   : mem_access
// Brief    : MEM-stage req/ack access unit with timeout; owns MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwrite,
    input  logic        memtoreg,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        byteword,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dst_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_alu,
    output logic [4:0]  wb_dst,
    output logic        exc_misaligned,
    output logic        mem_err
);

    localparam int             CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(TIMEOUT - 1);

    ma_state_e r_state_q;
    logic [CW-1:0] r_cnt_q;
    logic          r_err_q;
    memwb_t        r_wb_q;

    logic        w_access;
    logic        w_mis;
    logic        w_issue;
    logic        w_timeout;
    logic [31:0] w_ld_data;

    assign w_access = memread | memwrite;

    mem_lane_align u_align (
        .access_i     (w_access),
        .memwrite_i   (memwrite),
        .byteword_i   (byteword),
        .lane_i       (alu_result[1:0]),
        .store_data_i (store_data),
        .rdata_i      (mem_rdata),
        .be_o         (mem_be),
        .wdata_o      (mem_wdata),
        .rdata_o      (w_ld_data),
        .misaligned_o (w_mis)
    );

    assign w_issue   = (r_state_q == MA_IDLE) && w_access && !w_mis;
    // Last BUSY cycle without ack; an ack in this same cycle takes priority.
    assign w_timeout = (r_state_q == MA_BUSY) && !mem_ack && (r_cnt_q == C_CNT_LAST);

    assign mem_req        = w_issue || (r_state_q == MA_BUSY);
    assign stall          = w_issue || ((r_state_q == MA_BUSY) && !mem_ack && !w_timeout);
    assign mem_we         = memwrite;
    assign mem_addr       = {alu_result[31:2], 2'b00};
    assign exc_misaligned = (r_state_q == MA_IDLE) && w_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= MA_IDLE;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            r_wb_q    <= '0;
        end else begin
            case (r_state_q)
                MA_IDLE: begin
                    if (!w_access) begin
                        r_wb_q <= '{regwrite: regwrite, memtoreg: memtoreg, rdata: 32'h0,
                                    alu: alu_result, dst: dst_reg};
                    end else if (w_mis) begin
                        r_wb_q <= '{regwrite: 1'b0, memtoreg: 1'b0, rdata: 32'h0,
                                    alu: alu_result, dst: dst_reg};
                    end else begin
                        r_state_q <= MA_BUSY;
                        r_cnt_q   <= '0;
                    end
                end
                MA_BUSY: begin
                    if (mem_ack) begin
                        r_wb_q <= '{regwrite: regwrite & ~memwrite, memtoreg: memtoreg,
                                    rdata: (memread & ~memwrite) ? w_ld_data : 32'h0,
                                    alu: alu_result, dst: dst_reg};
                        r_state_q <= MA_IDLE;
                    end else if (w_timeout) begin
                        r_err_q   <= 1'b1;
                        r_cnt_q   <= r_cnt_q + 1'b1;
                        r_wb_q    <= '{regwrite: 1'b0, memtoreg: 1'b0, rdata: 32'h0,
                                       alu: alu_result, dst: dst_reg};
                        r_state_q <= MA_IDLE;
                    end else begin
                        r_cnt_q <= r_cnt_q + 1'b1;
                    end
                end
                default: r_state_q <= MA_IDLE;
            endcase
        end
    end

    assign wb_regwrite = r_wb_q.regwrite;
    assign wb_memtoreg = r_wb_q.memtoreg;
    assign wb_rdata    = r_wb_q.rdata;
    assign wb_alu      = r_wb_q.alu;
    assign wb_dst      = r_wb_q.dst;
    assign mem_err     = r_err_q;

endmodule

`default_nettype wire
